// File: rtl/event_det_pkg.sv
// event_det_pkg: edge-detector mode encodings and the mode qualification helper
package event_det_pkg;
  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;
  function automatic logic mode_hit(input logic [1:0] mode, input logic rise);
    return (mode != MODE_OFF) &&
           (rise ? (mode == MODE_RISE || mode == MODE_BOTH)
                 : (mode == MODE_FALL || mode == MODE_BOTH));
  endfunction
endpackage

// File: rtl/event_detector_multi_if.sv
// event_detector_multi_if: pin-side inputs and register-side outputs of the event detector
interface event_detector_multi_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
);
  logic [N_CH-1:0]       i_Data;
  logic [2*N_CH-1:0]     i_Mode;
  logic [N_CH-1:0]       i_Clear;
  logic [N_CH-1:0]       o_Event;
  logic [N_CH-1:0]       o_Pending;
  logic [N_CH*CNT_W-1:0] o_Count;
  logic                  o_Irq;
  modport master (output i_Data, i_Mode, i_Clear, input o_Event, o_Pending, o_Count, o_Irq);
  modport slave  (input i_Data, i_Mode, i_Clear, output o_Event, o_Pending, o_Count, o_Irq);
endinterface

// File: rtl/event_det_channel.sv
// event_det_channel: synchroniser, glitch filter, mode-qualified edge detect, pending flag and saturating count
module event_det_channel
  import event_det_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_i,
  input  logic [1:0]       mode_i,
  input  logic             clear_i,
  output logic             event_o,
  output logic             pending_o,
  output logic [CNT_W-1:0] count_o
);
  localparam int MW = $clog2(FILT_LEN + 1);
  localparam logic [MW-1:0] M_LAST = MW'(FILT_LEN - 1);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [MW-1:0]          m_q, m_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, base;
  logic                   f_q, f_d, ev_q, ev_d, pend_q, pend_d, s, flip;
  // clear acts before the increment so a coinciding event leaves count at 1
  always_comb begin
    s      = sync_q[SYNC_STAGES-1];
    sync_d = {sync_q[SYNC_STAGES-2:0], data_i};
    flip   = (s != f_q) && (m_q == M_LAST);
    f_d    = flip ? s : f_q;
    m_d    = (s == f_q || flip) ? '0 : m_q + MW'(1);
    ev_d   = flip && mode_hit(mode_i, s);
    base   = clear_i ? '0 : cnt_q;
    cnt_d  = (ev_d && base != '1) ? base + CNT_W'(1) : base;
    pend_d = ev_d || (pend_q && !clear_i);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      m_q    <= '0;
      cnt_q  <= '0;
      f_q    <= 1'b0;
      ev_q   <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      m_q    <= m_d;
      cnt_q  <= cnt_d;
      f_q    <= f_d;
      ev_q   <= ev_d;
      pend_q <= pend_d;
    end
  end
  assign event_o   = ev_q;
  assign pending_o = pend_q;
  assign count_o   = cnt_q;
endmodule

// File: rtl/event_detector_multi.sv
// event_detector_multi: N_CH independent filtered edge detectors with a registered combined interrupt
module event_detector_multi
  import event_det_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int CNT_W       = 8
) (
  input logic                   clk,
  input logic                   reset,
  event_detector_multi_if.slave bus
);
  logic [N_CH-1:0]       ev_w, pend_w;
  logic [N_CH*CNT_W-1:0] cnt_w;
  logic                  irq_q, irq_d;
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    event_det_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_LEN   (FILT_LEN),
      .CNT_W      (CNT_W)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .data_i   (bus.i_Data[c]),
      .mode_i   (bus.i_Mode[2*c +: 2]),
      .clear_i  (bus.i_Clear[c]),
      .event_o  (ev_w[c]),
      .pending_o(pend_w[c]),
      .count_o  (cnt_w[c*CNT_W +: CNT_W])
    );
  end
  always_comb irq_d = |pend_w;
  always_ff @(posedge clk) begin
    if (reset) irq_q <= 1'b0;
    else irq_q <= irq_d;
  end
  assign bus.o_Event   = ev_w;
  assign bus.o_Pending = pend_w;
  assign bus.o_Count   = cnt_w;
  assign bus.o_Irq     = irq_q;
endmodule

// File: doc/event_detector_multi.md
# event_detector_multi

Multi-channel, parametrised event detector for asynchronous single-bit inputs. Each channel passes through its own synchroniser and glitch filter, then a per-channel edge detector with a selectable mode (rising, falling, both or off). Each detected event produces a one-cycle pulse, a sticky pending flag and a saturating event count. The block sits between external status/interrupt pins and the register/interrupt logic, and replaces single-channel rising-edge detectors.

## Interface
- `N_CH`, 4, number of independent channels.
- `SYNC_STAGES`, 2, synchroniser flops per channel; legal range ≥ 2.
- `FILT_LEN`, 3, consecutive synchronised cycles a new level must hold before it is accepted; legal range ≥ 1.
- `CNT_W`, 8, width of each per-channel saturating event counter.
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `i_Data`  in  N_CH  asynchronous input levels, bit c = channel c.
- `i_Mode`  in  2*N_CH  per-channel mode, bits [2c+1:2c]: 00 off, 01 rising, 10 falling, 11 both edges.
- `i_Clear`  in  N_CH  per-channel clear of pending flag and count; level-sampled, acts on every edge it is high.
- `o_Event`  out  N_CH  one-cycle event pulse per channel.
- `o_Pending`  out  N_CH  sticky flag per channel; set by an event, cleared by `i_Clear`.
- `o_Count`  out  N_CH*CNT_W  per-channel event count; channel c occupies bits [c*CNT_W +: CNT_W].
- `o_Irq`  out  1  OR of all `o_Pending` bits, registered.

## Operation
- **Synchroniser:** a `SYNC_STAGES`-deep flop chain per channel. `s` is the last stage.
- **Filter:**
  - Each channel holds a filtered level `f` and a mismatch counter `m` of width `$clog2(FILT_LEN+1)`.
  - On each edge where `s != f`: if `m == FILT_LEN-1`, then `f <= s` and `m <= 0`; otherwise `m <= m+1`.
  - On each edge where `s == f`: `m <= 0`. A pulse shorter than `FILT_LEN` synchronised cycles is discarded.
- **Edge qualification:** an event occurs on the edge where `f` changes.
  - The change is rising when `f` goes 0→1 and falling when it goes 1→0.
  - The event is qualified by the channel mode in effect at that edge.
  - Mode 00 suppresses events, but the filter keeps tracking the input.
- **Event effects** (registered, same edge):
  - `o_Event[c] <= 1` for exactly one cycle.
  - `o_Pending[c] <= 1`.
  - `o_Count[c] <= min(count+1, 2^CNT_W-1)`. The counter saturates and never wraps.
- **Clear:** `i_Clear[c]` high sets `o_Pending[c] <= 0` and the count to 0.
- **Clear and event on the same edge:** the event wins. Pending ends at 1 and the count ends at 1 (clear, then increment).
- **Mode changes** take effect on the next edge. They never reset `f`, `m`, pending or count.
- **Channels** are fully independent. Simultaneous events on several channels are all reported in the same cycle.
- **Reset values:** all sync flops, `f` and `m` are 0; `o_Event`, `o_Pending`, `o_Count` and `o_Irq` are 0.
- **Inputs high at reset release:** `f` rises after the normal latency and produces a rising event if the mode permits.
- **Reset asserted mid-filter or mid-count:** all state returns to the reset values on that edge, and no event is emitted in the following cycle.

## Timing
- Take an input level change as captured at edge 0.
- `s` reflects it after edge `SYNC_STAGES-1`.
- `f` updates, and `o_Event` is high, in the cycle following edge `SYNC_STAGES+FILT_LEN-1`. With the defaults this is edge 4.
- `o_Pending` and `o_Count` update on the same edge as `o_Event`. `o_Irq` follows one edge later.
- Minimum accepted pulse width is `FILT_LEN` cycles once synchronised.
- Back-to-back events on one channel are at least `FILT_LEN` cycles apart.
- No combinational path exists from any input to any output.

## Structure
- Package `event_det_pkg`:
  - mode constants `MODE_OFF`=2'b00, `MODE_RISE`=2'b01, `MODE_FALL`=2'b10, `MODE_BOTH`=2'b11
  - a helper function for the mode qualification
- Sub-module `event_det_channel`: synchroniser, filter, edge qualification, pending flag and saturating counter for one channel. It takes the same parameters minus `N_CH`.
- The top level generates `N_CH` instances, packs their outputs and registers `o_Irq`.

## Test plan
- **Rising detection with defaults, channel 0 mode 01:** `i_Data[0]` goes 0→1 at edge 0 and holds → `o_Event[0]` pulses one cycle after edge 4. `o_Pending[0]`=1, count=1, `o_Irq`=1 one cycle later.
- **Glitch rejection:** `i_Data[1]` high for 2 cycles, mode 11 → no event and count stays 0. The same stimulus held for 3 cycles → exactly one rising event, and one falling event after it drops.
- **Modes:** drive the same 0→1→0 sequence on all 4 channels with modes 00/01/10/11 → counts 0/1/1/2 and pending 0/1/1/1.
- **Clear and event on the same edge, channel 2:**
  - With count=5, assert `i_Clear[2]` on the event edge → pending=1, count=1.
  - A clear alone → pending=0, count=0, and `o_Irq` falls one cycle later.
- **Saturation with `CNT_W`=2:** 5 events → count reads 1, 2, 3, 3, 3.
- **Reset behaviour:**
  - Assert `reset` mid-filter, 2 cycles into a 3-cycle pulse → no event, and all outputs 0.
  - Release reset with `i_Data`=all ones, modes 01 → every channel fires once, 4 cycles after the first edge following release.
